// File: rtl/reg_pipe_mux_param.sv
// Purpose: parametrised register pipeline / bypass mux with sync clear, per-stage valid and occupancy count.
// Latency: DEPTH clken-qualified edges from a to b (DEPTH=0 is a combinational wire-through).
// Backpressure: none; a full pipe keeps shifting while the oldest word leaves on b.
module reg_pipe_mux_param #(
   parameter int unsigned      WIDTH     = 48,
   parameter int unsigned      DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      CNT_W     = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clken,
   input  logic             sclr,
   input  logic [WIDTH-1:0] a,
   input  logic             a_valid,
   output logic [WIDTH-1:0] b,
   output logic             b_valid,
   output logic [CNT_W-1:0] fill_cnt,
   output logic             full,
   output logic             empty
);

   generate
      if (DEPTH == 0) begin : g_bypass
         // No storage: the pipe is always both empty and full, and clock,
         // clear and reset cannot touch the through path.
         assign b        = a;
         assign b_valid  = a_valid;
         assign fill_cnt = '0;
         assign empty    = 1'b1;
         assign full     = 1'b1;
      end else begin : g_pipe
         logic [WIDTH-1:0] s_q [DEPTH];
         logic [DEPTH-1:0] v_q;
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // Occupancy tracks entries minus exits; a simultaneous valid entry
         // and valid exit cancel so the count never leaves 0..DEPTH.
         always_comb begin
            cnt_d = cnt_q;
            if (a_valid && !v_q[DEPTH-1]) begin
               cnt_d = cnt_q + 1'b1;
            end else if (!a_valid && v_q[DEPTH-1]) begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         // Data/valid shift register: reset, then sclr, then clken; data moves
         // even for invalid slots so the bubble pattern is preserved.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               for (int i = 0; i < int'(DEPTH); i++) begin
                  s_q[i] <= RESET_VAL;
               end
               v_q <= '0;
            end else if (sclr) begin
               for (int i = 0; i < int'(DEPTH); i++) begin
                  s_q[i] <= RESET_VAL;
               end
               v_q <= '0;
            end else if (clken) begin
               s_q[0] <= a;
               v_q[0] <= a_valid;
               for (int i = 1; i < int'(DEPTH); i++) begin
                  s_q[i] <= s_q[i-1];
                  v_q[i] <= v_q[i-1];
               end
            end
         end

         // Occupancy counter follows the same priority as the stages it counts.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt_q <= '0;
            end else if (sclr) begin
               cnt_q <= '0;
            end else if (clken) begin
               cnt_q <= cnt_d;
            end
         end

         assign b        = s_q[DEPTH-1];
         assign b_valid  = v_q[DEPTH-1];
         assign fill_cnt = cnt_q;
         assign full     = (cnt_q == CNT_W'(DEPTH));
         assign empty    = (cnt_q == '0);
      end
   endgenerate

endmodule

// File: tb/tb_reg_pipe_mux_param.sv
// Bench for reg_pipe_mux_param: five instances (DEPTH 0..4) share one stimulus stream.
// Reference model is a per-instance push log since the last clear; b is the push DEPTH entries back.
// Directed scenarios add literal expectations that pin the model.
module tb_reg_pipe_mux_param;
   localparam int W = 48;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset;
   logic         clken;
   logic         sclr;
   logic [W-1:0] a;
   logic         a_valid;

   logic [W-1:0] ob  [5];
   logic         obv [5];
   logic         ofu [5];
   logic         oem [5];
   logic [2:0]   ofc [5];
   logic [0:0]   fc0, fc1;
   logic [1:0]   fc2, fc3;
   logic [2:0]   fc4;

   assign ofc[0] = {2'b00, fc0};
   assign ofc[1] = {2'b00, fc1};
   assign ofc[2] = {1'b0, fc2};
   assign ofc[3] = {1'b0, fc3};
   assign ofc[4] = fc4;

   reg_pipe_mux_param #(.WIDTH(W), .DEPTH(0), .RESET_VAL(48'h0)) u_d0 (
      .clk(clk), .reset(reset), .clken(clken), .sclr(sclr), .a(a), .a_valid(a_valid),
      .b(ob[0]), .b_valid(obv[0]), .fill_cnt(fc0), .full(ofu[0]), .empty(oem[0]));
   reg_pipe_mux_param #(.WIDTH(W), .DEPTH(1), .RESET_VAL(48'h0)) u_d1 (
      .clk(clk), .reset(reset), .clken(clken), .sclr(sclr), .a(a), .a_valid(a_valid),
      .b(ob[1]), .b_valid(obv[1]), .fill_cnt(fc1), .full(ofu[1]), .empty(oem[1]));
   reg_pipe_mux_param #(.WIDTH(W), .DEPTH(2), .RESET_VAL(48'h0)) u_d2 (
      .clk(clk), .reset(reset), .clken(clken), .sclr(sclr), .a(a), .a_valid(a_valid),
      .b(ob[2]), .b_valid(obv[2]), .fill_cnt(fc2), .full(ofu[2]), .empty(oem[2]));
   reg_pipe_mux_param #(.WIDTH(W), .DEPTH(3), .RESET_VAL(48'h0)) u_d3 (
      .clk(clk), .reset(reset), .clken(clken), .sclr(sclr), .a(a), .a_valid(a_valid),
      .b(ob[3]), .b_valid(obv[3]), .fill_cnt(fc3), .full(ofu[3]), .empty(oem[3]));
   reg_pipe_mux_param #(.WIDTH(W), .DEPTH(4), .RESET_VAL(48'h5A)) u_d4 (
      .clk(clk), .reset(reset), .clken(clken), .sclr(sclr), .a(a), .a_valid(a_valid),
      .b(ob[4]), .b_valid(obv[4]), .fill_cnt(fc4), .full(ofu[4]), .empty(oem[4]));

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Model: instance k has DEPTH k. Log of enabled pushes since the last clear.
   logic [W-1:0] log_d [5][256];
   logic         log_v [5][256];
   int           n_push [5] = '{0, 0, 0, 0, 0};

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 5; k++) n_push[k] <= 0;
      end else if (sclr) begin
         for (int k = 0; k < 5; k++) n_push[k] <= 0;
      end else if (clken) begin
         for (int k = 0; k < 5; k++) begin
            log_d[k][n_push[k] & 255] <= a;
            log_v[k][n_push[k] & 255] <= a_valid;
            n_push[k] <= n_push[k] + 1;
         end
      end
   end

   function automatic logic [W-1:0] rv(int k);
      return (k == 4) ? 48'h5A : 48'h0;
   endfunction

   function automatic logic [W-1:0] exp_b(int k);
      if (k == 0) return a;
      if (n_push[k] >= k) return log_d[k][(n_push[k] - k) & 255];
      return rv(k);
   endfunction

   function automatic logic exp_bv(int k);
      if (k == 0) return a_valid;
      if (n_push[k] >= k) return log_v[k][(n_push[k] - k) & 255];
      return 1'b0;
   endfunction

   function automatic int exp_fill(int k);
      int lo, c;
      c  = 0;
      lo = (n_push[k] > k) ? n_push[k] - k : 0;
      for (int j = lo; j < n_push[k]; j++) if (log_v[k][j & 255]) c++;
      return c;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every negedge, all five instances are compared against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 5; k++) begin
            int ef;
            ef = exp_fill(k);
            check($sformatf("model_b[D%0d]", k), ob[k], exp_b(k));
            check($sformatf("model_bv[D%0d]", k), {47'b0, obv[k]}, {47'b0, exp_bv(k)});
            check($sformatf("model_fill[D%0d]", k), {45'b0, ofc[k]}, W'(ef));
            check($sformatf("model_full[D%0d]", k), {47'b0, ofu[k]}, {47'b0, (ef == k)});
            check($sformatf("model_empty[D%0d]", k), {47'b0, oem[k]}, {47'b0, (ef == 0)});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int fill_seq3 [6] = '{1, 2, 3, 3, 3, 2};
   int av_pat2   [5] = '{1, 0, 1, 1, 1};
   int fill_exp2 [5] = '{1, 1, 1, 2, 2};
   int bv_exp2   [5] = '{0, 1, 0, 1, 1};
   int full_exp2 [5] = '{0, 0, 0, 1, 1};

   initial begin
      reset   = 1'b0;
      clken   = 1'b0;
      sclr    = 1'b0;
      a       = 48'hFFFF_FFFF_FFFF;
      a_valid = 1'b0;
      cyc();
      chk_en = 1'b1;
      cyc();

      // Reset / idle
      check("rst_b_d1", ob[1], 48'h0);
      check("rst_bv_d1", {47'b0, obv[1]}, 48'h0);
      check("rst_empty_d1", {47'b0, oem[1]}, 48'h1);
      check("rst_full_d1", {47'b0, ofu[1]}, 48'h0);
      check("rst_b_d4", ob[4], 48'h5A);
      reset   = 1'b1;
      clken   = 1'b1;
      a_valid = 1'b1;
      cyc();
      check("rel_b_d1", ob[1], 48'hFFFF_FFFF_FFFF);
      check("rel_bv_d1", {47'b0, obv[1]}, 48'h1);
      check("rel_fill_d1", {45'b0, ofc[1]}, 48'h1);
      check("rel_full_d1", {47'b0, ofu[1]}, 48'h1);

      // Latency and clock enable, DEPTH=3
      sclr = 1'b1; cyc(); sclr = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         a = W'(i); a_valid = 1'b1; clken = 1'b1;
         cyc();
         check($sformatf("lat_fill%0d_d3", i), {45'b0, ofc[3]}, W'(fill_seq3[i-1]));
      end
      check("lat_b3_d3", ob[3], 48'h1);
      clken = 1'b0; a = 48'h99;
      for (int i = 0; i < 2; i++) begin
         cyc();
         check("hold_b_d3", ob[3], 48'h1);
         check("hold_fill_d3", {45'b0, ofc[3]}, W'(fill_seq3[3+i]));
      end
      clken = 1'b1; a_valid = 1'b0; a = 48'h77;
      cyc();
      check("adv_b_d3", ob[3], 48'h2);
      check("adv_fill_d3", {45'b0, ofc[3]}, W'(fill_seq3[5]));

      // Sync clear vs clken, DEPTH=4, RESET_VAL=5A
      sclr = 1'b1; cyc(); sclr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a = 48'h10 + W'(i); a_valid = 1'b1; cyc();
      end
      check("fill4_full_d4", {47'b0, ofu[4]}, 48'h1);
      check("fill4_b_d4", ob[4], 48'h10);
      sclr = 1'b1; clken = 1'b1; a = 48'hDEAD; a_valid = 1'b1;
      cyc();
      check("sclr_b_d4", ob[4], 48'h5A);
      check("sclr_bv_d4", {47'b0, obv[4]}, 48'h0);
      check("sclr_fill_d4", {45'b0, ofc[4]}, 48'h0);
      check("sclr_empty_d4", {47'b0, oem[4]}, 48'h1);
      sclr = 1'b0; a = 48'h0; a_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("sclr_nodead_d4", {47'b0, (ob[4] == 48'hDEAD)}, 48'h0);
      end

      // Bubble tracking, DEPTH=2
      sclr = 1'b1; cyc(); sclr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a = 48'h100 + W'(i); a_valid = av_pat2[i][0];
         cyc();
         check($sformatf("bub_fill%0d_d2", i), {46'b0, ofc[2][1:0]}, W'(fill_exp2[i]));
         check($sformatf("bub_bv%0d_d2", i), {47'b0, obv[2]}, W'(bv_exp2[i]));
         check($sformatf("bub_full%0d_d2", i), {47'b0, ofu[2]}, W'(full_exp2[i]));
      end

      // Async reset mid-operation, DEPTH=3
      sclr = 1'b1; cyc(); sclr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 48'h21 + W'(i); a_valid = 1'b1; cyc();
      end
      check("pre_full_d3", {47'b0, ofu[3]}, 48'h1);
      check("pre_b_d3", ob[3], 48'h21);
      #2;
      reset = 1'b0;
      #1;
      check("arst_b_d3", ob[3], 48'h0);
      check("arst_bv_d3", {47'b0, obv[3]}, 48'h0);
      check("arst_fill_d3", {45'b0, ofc[3]}, 48'h0);
      check("arst_empty_d3", {47'b0, oem[3]}, 48'h1);
      check("arst_b_d4", ob[4], 48'h5A);
      cyc();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = 48'h31 + W'(i); a_valid = 1'b1; cyc();
         if (i == 0) check("refill1_bv_d3", {47'b0, obv[3]}, 48'h0);
      end
      check("refill_b_d3", ob[3], 48'h31);
      check("refill_fill_d3", {45'b0, ofc[3]}, 48'h3);

      // Bypass, DEPTH=0, with sclr high and a reset pulse
      sclr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] av;
         av = i[0] ? 48'hAAAA_AAAA_AAAA : 48'h5555_5555_5555;
         a = av; a_valid = i[1];
         reset = (i == 3 || i == 4) ? 1'b0 : 1'b1;
         #1;
         check("byp_b_d0", ob[0], av);
         check("byp_bv_d0", {47'b0, obv[0]}, W'(i[1]));
         check("byp_fill_d0", {45'b0, ofc[0]}, 48'h0);
         check("byp_empty_d0", {47'b0, oem[0]}, 48'h1);
         check("byp_full_d0", {47'b0, ofu[0]}, 48'h1);
         cyc();
      end
      sclr = 1'b0; reset = 1'b1;
      cyc();
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
